saturn_exec_sequencer: RTL and testbench

- Executes what saturn_inst_decoder produces, and sits between the decoder and the PC, ALU and reset logic.
- For a JUMP it gathers the offset nibbles and computes the target PC.
- For an ALU op it issues one ALU step per nibble from ptr_begin to ptr_end.
- For a RESET it issues a reset request.
- It raises busy so fetch and decode stall until execution finishes.

---
 rtl/saturn_exec_sequencer_pkg.sv | 35 +++
 rtl/saturn_jump_target.sv | 46 ++++
 rtl/saturn_exec_sequencer.sv | 242 ++++++++++++++++++++++++
 tb/tb_saturn_exec_sequencer.sv | 423 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/saturn_exec_sequencer_pkg.sv
// saturn_exec_sequencer_pkg
// Definitions shared by the execution sequencer and its helpers. This extends
// the decoder's instruction-type set (saturn_def_alu.v) so that the decoder and
// the sequencer agree on one set of encodings.
//   INSTR_TYPE_*  : instruction type codes produced by saturn_inst_decoder
//   JUMP_LEN_ABS  : jump_length value that selects an absolute 5-nibble jump
//   OFFSET_W      : width of the collected jump offset (5 nibbles)
//   seq_state_e   : sequencer FSM states
package saturn_exec_sequencer_pkg;

  localparam logic [3:0] INSTR_TYPE_NOP   = 4'd0;
  localparam logic [3:0] INSTR_TYPE_ALU   = 4'd1;
  localparam logic [3:0] INSTR_TYPE_JUMP  = 4'd2;
  localparam logic [3:0] INSTR_TYPE_RESET = 4'd3;
  localparam logic [3:0] INSTR_TYPE_NONE  = 4'd15;

  localparam logic [2:0] JUMP_LEN_ABS = 3'd4;

  localparam int unsigned OFFSET_W = 20;

  typedef enum logic [2:0] {
    IDLE,
    J_COLLECT,
    J_APPLY,
    A_RUN,
    R_REQ,
    ERR
  } seq_state_e;

  // Number of offset nibbles a jump of the given encoded length carries.
  function automatic logic [3:0] jump_nibbles(input logic [2:0] len);
    return {1'b0, len} + 4'd1;
  endfunction

endpackage

// File: rtl/saturn_jump_target.sv
// saturn_jump_target
// Combinational jump-target calculator. Relative jumps (len < JUMP_LEN_ABS)
// sign-extend the collected offset from 4*(len+1) bits and add it to the
// address following the instruction start; len == JUMP_LEN_ABS uses the offset
// directly as an absolute address. Kept separate so GOSUB/return paths can
// reuse it.
// Ports:
//   instr_pc_i [PC_W-1:0]     start address of the jump instruction
//   offset_i   [OFFSET_W-1:0] offset nibbles, least significant nibble first
//   len_i      [2:0]          offset nibble count minus 1
//   target_o   [PC_W-1:0]     computed target (zero for len > JUMP_LEN_ABS)
// PC_W must be greater than 16 so the widest relative offset fits.
module saturn_jump_target
  import saturn_exec_sequencer_pkg::*;
#(
  parameter int unsigned PC_W = 20
) (
  input  logic [PC_W-1:0]     instr_pc_i,
  input  logic [OFFSET_W-1:0] offset_i,
  input  logic [2:0]          len_i,
  output logic [PC_W-1:0]     target_o
);

  logic [PC_W-1:0] rel_off;

  always_comb begin
    rel_off = '0;
    case (len_i)
      3'd0:    rel_off = {{(PC_W-4){offset_i[3]}},   offset_i[3:0]};
      3'd1:    rel_off = {{(PC_W-8){offset_i[7]}},   offset_i[7:0]};
      3'd2:    rel_off = {{(PC_W-12){offset_i[11]}}, offset_i[11:0]};
      3'd3:    rel_off = {{(PC_W-16){offset_i[15]}}, offset_i[15:0]};
      default: rel_off = '0;
    endcase
  end

  always_comb begin
    target_o = '0;
    if (len_i == JUMP_LEN_ABS) begin
      target_o = PC_W'(offset_i);
    end else if (len_i < JUMP_LEN_ABS) begin
      target_o = instr_pc_i + PC_W'(1) + rel_off;
    end
  end

endmodule

// File: rtl/saturn_exec_sequencer.sv
// saturn_exec_sequencer
// Executes decoded instructions between saturn_inst_decoder and the PC, ALU
// and reset logic. JUMPs collect their offset nibbles and load a new PC, ALU
// ops issue one ALU step per nibble from ptr_begin to ptr_end (wrapping mod
// 16), RESET issues a soft-reset request. o_exec_busy stalls fetch/decode
// while an instruction executes. All outputs are registered.
// Ports:
//   i_clk, i_reset (async, active-high), i_clk_en (global enable)
//   i_phases[3:0]      one-hot phase strobes
//   i_bus_busy         offset nibbles invalid while high
//   i_nibble[3:0]      current fetch nibble
//   i_instr_pc, i_instr_type, i_instr_execute, i_jump_length,
//   i_alu_ptr_begin, i_alu_ptr_end    decoder outputs
//   o_pc_load/o_pc_new                PC load strobe and jump target
//   o_alu_step/o_alu_ptr/o_alu_last   ALU step strobe, nibble index, final step
//   o_reset_req                       soft-reset request strobe
//   o_exec_busy, o_exec_error         busy and sticky unsupported-type flag
// Optional: define SATURN_EXEC_TRACE_EN to add o_dbg_retired[31:0], a count of
// retired JUMP/ALU/RESET instructions, plus a simulation trace line per
// retirement.
module saturn_exec_sequencer
  import saturn_exec_sequencer_pkg::*;
#(
  parameter int unsigned PC_W = 20
) (
  input  logic            i_clk,
  input  logic            i_reset,
  input  logic            i_clk_en,
  input  logic [3:0]      i_phases,
  input  logic            i_bus_busy,
  input  logic [3:0]      i_nibble,
  input  logic [PC_W-1:0] i_instr_pc,
  input  logic [3:0]      i_instr_type,
  input  logic            i_instr_execute,
  input  logic [2:0]      i_jump_length,
  input  logic [3:0]      i_alu_ptr_begin,
  input  logic [3:0]      i_alu_ptr_end,
  output logic            o_pc_load,
  output logic [PC_W-1:0] o_pc_new,
  output logic            o_alu_step,
  output logic [3:0]      o_alu_ptr,
  output logic            o_alu_last,
  output logic            o_reset_req,
  output logic            o_exec_busy,
  output logic            o_exec_error
`ifdef SATURN_EXEC_TRACE_EN
  ,
  output logic [31:0]     o_dbg_retired
`endif
);

  seq_state_e          state_q;
  logic [PC_W-1:0]     pc_q;
  logic [OFFSET_W-1:0] offset_q;
  logic [OFFSET_W-1:0] offset_d;
  logic [2:0]          len_q;
  logic [2:0]          cnt_q;
  logic [3:0]          ptr_q;
  logic [3:0]          end_q;

  logic                pc_load_q;
  logic [PC_W-1:0]     pc_new_q;
  logic                alu_step_q;
  logic [3:0]          alu_ptr_q;
  logic                alu_last_q;
  logic                reset_req_q;
  logic                busy_q;
  logic                error_q;

  logic [PC_W-1:0]     target_w;

  saturn_jump_target #(
    .PC_W(PC_W)
  ) u_jump_target (
    .instr_pc_i(pc_q),
    .offset_i  (offset_q),
    .len_i     (len_q),
    .target_o  (target_w)
  );

  // Insert the incoming nibble at the current count. Nibbles beyond the fifth
  // only occur for illegal lengths that end in ERR, so they are not stored.
  always_comb begin
    offset_d = offset_q;
    case (cnt_q)
      3'd0:    offset_d[3:0]   = i_nibble;
      3'd1:    offset_d[7:4]   = i_nibble;
      3'd2:    offset_d[11:8]  = i_nibble;
      3'd3:    offset_d[15:12] = i_nibble;
      3'd4:    offset_d[19:16] = i_nibble;
      default: offset_d = offset_q;
    endcase
  end

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      state_q     <= IDLE;
      pc_q        <= '0;
      offset_q    <= '0;
      len_q       <= '0;
      cnt_q       <= '0;
      ptr_q       <= '0;
      end_q       <= '0;
      pc_load_q   <= 1'b0;
      pc_new_q    <= '0;
      alu_step_q  <= 1'b0;
      alu_ptr_q   <= '0;
      alu_last_q  <= 1'b0;
      reset_req_q <= 1'b0;
      busy_q      <= 1'b0;
      error_q     <= 1'b0;
    end else if (i_clk_en) begin
      pc_load_q   <= 1'b0;
      alu_step_q  <= 1'b0;
      alu_last_q  <= 1'b0;
      reset_req_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (i_phases[3] && i_instr_execute) begin
            case (i_instr_type)
              INSTR_TYPE_JUMP: begin
                len_q    <= i_jump_length;
                pc_q     <= i_instr_pc;
                offset_q <= '0;
                cnt_q    <= '0;
                busy_q   <= 1'b1;
                state_q  <= J_COLLECT;
              end
              INSTR_TYPE_ALU: begin
                ptr_q   <= i_alu_ptr_begin;
                end_q   <= i_alu_ptr_end;
                busy_q  <= 1'b1;
                state_q <= A_RUN;
              end
              INSTR_TYPE_RESET: begin
                busy_q  <= 1'b1;
                state_q <= R_REQ;
              end
              INSTR_TYPE_NOP, INSTR_TYPE_NONE: begin
                state_q <= IDLE;
              end
              default: begin
                error_q <= 1'b1;
                state_q <= ERR;
              end
            endcase
          end
        end
        J_COLLECT: begin
          if (i_phases[2] && !i_bus_busy) begin
            offset_q <= offset_d;
            if (cnt_q == len_q) begin
              state_q <= J_APPLY;
            end else begin
              cnt_q <= cnt_q + 3'd1;
            end
          end
        end
        J_APPLY: begin
          busy_q <= 1'b0;
          if (len_q > JUMP_LEN_ABS) begin
            error_q <= 1'b1;
            state_q <= ERR;
          end else begin
            pc_load_q <= 1'b1;
            pc_new_q  <= target_w;
            state_q   <= IDLE;
          end
        end
        A_RUN: begin
          if (i_phases[3]) begin
            alu_step_q <= 1'b1;
            alu_ptr_q  <= ptr_q;
            if (ptr_q == end_q) begin
              alu_last_q <= 1'b1;
              busy_q     <= 1'b0;
              state_q    <= IDLE;
            end else begin
              ptr_q <= ptr_q + 4'd1;
            end
          end
        end
        R_REQ: begin
          reset_req_q <= 1'b1;
          busy_q      <= 1'b0;
          state_q     <= IDLE;
        end
        ERR: begin
          busy_q  <= 1'b0;
          error_q <= 1'b1;
        end
        default: begin
          busy_q  <= 1'b0;
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign o_pc_load    = pc_load_q;
  assign o_pc_new     = pc_new_q;
  assign o_alu_step   = alu_step_q;
  assign o_alu_ptr    = alu_ptr_q;
  assign o_alu_last   = alu_last_q;
  assign o_reset_req  = reset_req_q;
  assign o_exec_busy  = busy_q;
  assign o_exec_error = error_q;

`ifdef SATURN_EXEC_TRACE_EN
  logic [31:0] retired_q;
  logic        retire_w;

  // Mirrors the FSM's return-to-IDLE conditions from J_APPLY, A_RUN and R_REQ.
  always_comb begin
    retire_w = 1'b0;
    if (i_clk_en) begin
      case (state_q)
        J_APPLY: retire_w = (len_q <= JUMP_LEN_ABS);
        A_RUN:   retire_w = i_phases[3] && (ptr_q == end_q);
        R_REQ:   retire_w = 1'b1;
        default: retire_w = 1'b0;
      endcase
    end
  end

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      retired_q <= '0;
    end else if (retire_w) begin
      retired_q <= retired_q + 32'd1;
      case (state_q)
        J_APPLY: $display("saturn_exec_sequencer: retire JUMP target=%h", target_w);
        A_RUN:   $display("saturn_exec_sequencer: retire ALU ptr=%h", ptr_q);
        default: $display("saturn_exec_sequencer: retire RESET");
      endcase
    end
  end

  assign o_dbg_retired = retired_q;
`endif

endmodule

// File: tb/tb_saturn_exec_sequencer.sv
module tb_saturn_exec_sequencer;

  localparam logic [3:0] T_NOP   = 4'd0;
  localparam logic [3:0] T_ALU   = 4'd1;
  localparam logic [3:0] T_JUMP  = 4'd2;
  localparam logic [3:0] T_RESET = 4'd3;
  localparam logic [3:0] T_NONE  = 4'd15;

  logic        clk = 1'b0;
  logic        i_reset = 1'b1;
  logic        i_clk_en = 1'b1;
  logic [3:0]  i_phases = 4'b0001;
  logic        i_bus_busy = 1'b0;
  logic [3:0]  i_nibble = 4'd0;
  logic [19:0] i_instr_pc = 20'd0;
  logic [3:0]  i_instr_type = T_NONE;
  logic        i_instr_execute = 1'b0;
  logic [2:0]  i_jump_length = 3'd0;
  logic [3:0]  i_alu_ptr_begin = 4'd0;
  logic [3:0]  i_alu_ptr_end = 4'd0;

  logic        o_pc_load;
  logic [19:0] o_pc_new;
  logic        o_alu_step;
  logic [3:0]  o_alu_ptr;
  logic        o_alu_last;
  logic        o_reset_req;
  logic        o_exec_busy;
  logic        o_exec_error;
`ifdef SATURN_EXEC_TRACE_EN
  logic [31:0] o_dbg_retired;
`endif

  int checks = 0;
  int errors = 0;
  int phase_idx = 0;

  always #5 clk = ~clk;

  saturn_exec_sequencer #(
    .PC_W(20)
  ) dut (
    .i_clk          (clk),
    .i_reset        (i_reset),
    .i_clk_en       (i_clk_en),
    .i_phases       (i_phases),
    .i_bus_busy     (i_bus_busy),
    .i_nibble       (i_nibble),
    .i_instr_pc     (i_instr_pc),
    .i_instr_type   (i_instr_type),
    .i_instr_execute(i_instr_execute),
    .i_jump_length  (i_jump_length),
    .i_alu_ptr_begin(i_alu_ptr_begin),
    .i_alu_ptr_end  (i_alu_ptr_end),
    .o_pc_load      (o_pc_load),
    .o_pc_new       (o_pc_new),
    .o_alu_step     (o_alu_step),
    .o_alu_ptr      (o_alu_ptr),
    .o_alu_last     (o_alu_last),
    .o_reset_req    (o_reset_req),
    .o_exec_busy    (o_exec_busy),
    .o_exec_error   (o_exec_error)
`ifdef SATURN_EXEC_TRACE_EN
    ,
    .o_dbg_retired  (o_dbg_retired)
`endif
  );

  // Reference: offset is the little-endian nibble value; relative jumps
  // treat it as a two's-complement number of 4*(len+1) bits.
  function automatic logic [19:0] jump_model(input logic [19:0] pc, input int len,
                                             input logic [31:0] nibs);
    longint span;
    longint off;
    longint sum;
    logic [19:0] r;
    span = longint'(1) << (4 * (len + 1));
    off  = longint'(nibs) & (span - 1);
    if (len == 4) begin
      r = off[19:0];
    end else begin
      if (off >= span / 2) off = off - span;
      sum = longint'(pc) + 1 + off;
      sum = sum & longint'(20'hFFFFF);
      r = sum[19:0];
    end
    return r;
  endfunction

  // One clock; outputs are sampled 1ns after the edge, then the phase
  // strobe rotates for the next edge. phase_idx is the phase the next edge sees.
  task automatic tick();
    @(posedge clk);
    #1;
    phase_idx = (phase_idx + 1) % 4;
    i_phases = 4'b0001 << phase_idx;
  endtask

  task automatic issue(input logic [3:0] t);
    int guard;
    guard = 0;
    while (phase_idx != 3 && guard < 8) begin
      tick();
      guard++;
    end
    i_instr_type = t;
    i_instr_execute = 1'b1;
    tick();
    i_instr_execute = 1'b0;
    i_instr_type = T_NONE;
  endtask

  task automatic pulse_reset();
    i_reset = 1'b1;
    tick();
    tick();
    i_reset = 1'b0;
    tick();
  endtask

  task automatic run_jump(input string name, input logic [19:0] pc, input logic [2:0] len,
                          input logic [31:0] nibs, input logic [15:0] stall_mask);
    int captured;
    int slot;
    int loads;
    int cyc;
    logic drove;
    logic stalled;
    logic done;
    logic load_at_drop;
    logic [19:0] got;
    logic [19:0] exp_pc;
    captured = 0; slot = 0; loads = 0; cyc = 0;
    done = 1'b0; load_at_drop = 1'b0; got = '0;
    exp_pc = (len <= 3'd4) ? jump_model(pc, int'(len), nibs) : 20'd0;
    i_instr_pc = pc;
    i_jump_length = len;
    issue(T_JUMP);
    checks++;
    if (o_exec_busy !== 1'b1) begin
      errors++;
      $display("FAIL %s busy_start: got %b expected 1", name, o_exec_busy);
    end
    while (!done && cyc < 400) begin
      drove = 1'b0;
      stalled = 1'b0;
      if (phase_idx == 2 && captured <= int'(len)) begin
        drove = 1'b1;
        if (slot < 16 && stall_mask[slot]) begin
          stalled = 1'b1;
          i_bus_busy = 1'b1;
          i_nibble = 4'($urandom);
        end else begin
          i_bus_busy = 1'b0;
          i_nibble = nibs[4*captured +: 4];
        end
        slot++;
      end else begin
        i_bus_busy = 1'($urandom_range(0, 1));
        i_nibble = 4'($urandom);
      end
      tick();
      cyc++;
      if (drove && !stalled) captured++;
      if (o_pc_load === 1'b1) begin
        loads++;
        got = o_pc_new;
      end
      if (o_exec_busy === 1'b0) begin
        done = 1'b1;
        load_at_drop = o_pc_load;
      end
    end
    i_bus_busy = 1'b0;
    checks++;
    if (!done) begin
      errors++;
      $display("FAIL %s timeout: busy still high after %0d cycles, expected drop", name, cyc);
    end
    tick();
    if (o_pc_load === 1'b1) loads++;
    if (len > 3'd4) begin
      checks++;
      if (o_exec_error !== 1'b1 || loads != 0) begin
        errors++;
        $display("FAIL %s len_error: error=%b loads=%0d expected error=1 loads=0",
                 name, o_exec_error, loads);
      end
    end else begin
      checks++;
      if (loads != 1 || load_at_drop !== 1'b1) begin
        errors++;
        $display("FAIL %s pc_load_pulse: loads=%0d at_busy_drop=%b expected 1 and 1",
                 name, loads, load_at_drop);
      end
      checks++;
      if (got !== exp_pc) begin
        errors++;
        $display("FAIL %s pc_new: got %05h expected %05h", name, got, exp_pc);
      end
    end
  endtask

  task automatic run_alu(input string name, input logic [3:0] b, input logic [3:0] e);
    int n;
    int idx;
    int cyc;
    logic done;
    logic last_at_drop;
    logic [3:0] exp_ptr;
    n = ((int'(e) + 16 - int'(b)) % 16) + 1;
    idx = 0; cyc = 0; done = 1'b0; last_at_drop = 1'b0;
    i_alu_ptr_begin = b;
    i_alu_ptr_end = e;
    issue(T_ALU);
    checks++;
    if (o_exec_busy !== 1'b1) begin
      errors++;
      $display("FAIL %s busy_start: got %b expected 1", name, o_exec_busy);
    end
    while (!done && cyc < 200) begin
      tick();
      cyc++;
      if (o_alu_step === 1'b1) begin
        exp_ptr = 4'((int'(b) + idx) % 16);
        checks++;
        if (o_alu_ptr !== exp_ptr || o_alu_last !== (idx == n - 1)) begin
          errors++;
          $display("FAIL %s step%0d: ptr=%h last=%b expected ptr=%h last=%b",
                   name, idx, o_alu_ptr, o_alu_last, exp_ptr, (idx == n - 1));
        end
        idx++;
      end else if (o_alu_last === 1'b1) begin
        checks++;
        errors++;
        $display("FAIL %s last_without_step: last=1 expected 0", name);
      end
      if (o_exec_busy === 1'b0) begin
        done = 1'b1;
        last_at_drop = o_alu_step & o_alu_last;
      end
    end
    checks++;
    if (!done || idx != n || last_at_drop !== 1'b1) begin
      errors++;
      $display("FAIL %s step_count: steps=%0d last_at_drop=%b done=%b expected %0d,1,1",
               name, idx, last_at_drop, done, n);
    end
    tick();
    checks++;
    if (o_alu_step !== 1'b0 || o_exec_busy !== 1'b0) begin
      errors++;
      $display("FAIL %s after_done: step=%b busy=%b expected 0 0", name, o_alu_step, o_exec_busy);
    end
  endtask

  task automatic test_reset();
    repeat (3) tick();
    checks++;
    if ({o_pc_load, o_pc_new, o_alu_step, o_alu_ptr, o_alu_last, o_reset_req,
         o_exec_busy, o_exec_error} !== '0) begin
      errors++;
      $display("FAIL reset_values: got load=%b pc=%05h step=%b ptr=%h last=%b rreq=%b busy=%b err=%b expected all 0",
               o_pc_load, o_pc_new, o_alu_step, o_alu_ptr, o_alu_last, o_reset_req,
               o_exec_busy, o_exec_error);
    end
    i_reset = 1'b0;
    tick();
  endtask

  task automatic test_jumps();
    run_jump("goto_fwd", 20'h00100, 3'd2, 32'h0000_0004, 16'h0000);
    run_jump("goto_back", 20'h00200, 3'd2, 32'h0000_0FFE, 16'h0000);
    run_jump("abs_stall", 20'h0ABCD, 3'd4, 32'h0001_2345, 16'h000C);
  endtask

  task automatic test_alu();
    run_alu("alu_wrap", 4'hE, 4'h1);
    run_alu("alu_full", 4'h0, 4'hF);
  endtask

  task automatic test_back_to_back();
    run_alu("alu_single", 4'h3, 4'h3);
    issue(T_RESET);
    checks++;
    if (o_exec_busy !== 1'b1 || o_reset_req !== 1'b0) begin
      errors++;
      $display("FAIL rreq_start: busy=%b rreq=%b expected 1 0", o_exec_busy, o_reset_req);
    end
    tick();
    checks++;
    if (o_exec_busy !== 1'b0 || o_reset_req !== 1'b1) begin
      errors++;
      $display("FAIL rreq_pulse: busy=%b rreq=%b expected 0 1", o_exec_busy, o_reset_req);
    end
    tick();
    checks++;
    if (o_reset_req !== 1'b0) begin
      errors++;
      $display("FAIL rreq_end: rreq=%b expected 0", o_reset_req);
    end
    issue(T_NOP);
    checks++;
    if (o_exec_busy !== 1'b0 || o_exec_error !== 1'b0) begin
      errors++;
      $display("FAIL nop: busy=%b err=%b expected 0 0", o_exec_busy, o_exec_error);
    end
    run_jump("jump_after_nop", 20'hFFFFE, 3'd0, 32'h0000_0003, 16'h0001);
  endtask

  task automatic test_clk_en();
    i_clk_en = 1'b0;
    i_alu_ptr_begin = 4'h2;
    i_alu_ptr_end = 4'h4;
    issue(T_ALU);
    repeat (6) tick();
    checks++;
    if (o_exec_busy !== 1'b0 || o_alu_step !== 1'b0) begin
      errors++;
      $display("FAIL clk_en_hold: busy=%b step=%b expected 0 0", o_exec_busy, o_alu_step);
    end
    i_clk_en = 1'b1;
    tick();
  endtask

  task automatic test_random();
    logic [2:0]  len;
    logic [15:0] stall;
    for (int i = 0; i < 12; i++) begin
      len = 3'($urandom_range(0, 4));
      stall = 16'($urandom) & 16'($urandom);
      run_jump($sformatf("rand_jump%0d", i), 20'($urandom), len, $urandom, stall);
    end
    for (int i = 0; i < 8; i++) begin
      run_alu($sformatf("rand_alu%0d", i), 4'($urandom), 4'($urandom));
    end
  endtask

  task automatic test_reset_mid_jump();
    i_instr_pc = 20'h00300;
    i_jump_length = 3'd4;
    issue(T_JUMP);
    while (phase_idx != 2) tick();
    i_nibble = 4'h9;
    i_bus_busy = 1'b0;
    tick();
    i_clk_en = 1'b0;
    #2;
    i_reset = 1'b1;
    #1;
    checks++;
    if ({o_pc_load, o_pc_new, o_alu_step, o_alu_ptr, o_alu_last, o_reset_req,
         o_exec_busy, o_exec_error} !== '0) begin
      errors++;
      $display("FAIL async_reset: busy=%b load=%b pc=%05h err=%b expected all outputs 0",
               o_exec_busy, o_pc_load, o_pc_new, o_exec_error);
    end
    tick();
    tick();
    i_reset = 1'b0;
    i_clk_en = 1'b1;
    repeat (8) tick();
    checks++;
    if (o_exec_busy !== 1'b0 || o_pc_load !== 1'b0) begin
      errors++;
      $display("FAIL reset_idle: busy=%b load=%b expected 0 0", o_exec_busy, o_pc_load);
    end
    run_alu("alu_after_reset", 4'h5, 4'h6);
  endtask

  task automatic test_errors();
    run_jump("jump_len5", 20'h01000, 3'd5, 32'h0065_4321, 16'h0000);
    pulse_reset();
    checks++;
    if (o_exec_error !== 1'b0) begin
      errors++;
      $display("FAIL err_clear_len5: err=%b expected 0", o_exec_error);
    end
    issue(4'd7);
    checks++;
    if (o_exec_error !== 1'b1 || o_exec_busy !== 1'b0) begin
      errors++;
      $display("FAIL type7: err=%b busy=%b expected 1 0", o_exec_error, o_exec_busy);
    end
    i_alu_ptr_begin = 4'h0;
    i_alu_ptr_end = 4'h1;
    issue(T_ALU);
    repeat (10) tick();
    checks++;
    if (o_exec_error !== 1'b1 || o_exec_busy !== 1'b0 || o_alu_step !== 1'b0) begin
      errors++;
      $display("FAIL err_sticky: err=%b busy=%b step=%b expected 1 0 0",
               o_exec_error, o_exec_busy, o_alu_step);
    end
    pulse_reset();
    checks++;
    if (o_exec_error !== 1'b0) begin
      errors++;
      $display("FAIL err_clear: err=%b expected 0", o_exec_error);
    end
    run_alu("alu_after_err", 4'hA, 4'hB);
  endtask

  initial begin
    test_reset();
    test_jumps();
    test_alu();
    test_back_to_back();
    test_clk_en();
    test_random();
    test_reset_mid_jump();
    test_errors();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
